if_prefetch: RTL

Parametrised instruction-fetch front end that replaces the single-register PC stage. It generates sequential fetch addresses, issues one outstanding request at a time to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue feeding decode. It supports branch/exception redirect with flush, including discard of an in-flight response, and honours the pipeline stall vector.

---
 rtl/if_prefetch.sv | 103 ++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// Fetch front end: one outstanding imem request feeding a DEPTH-entry first-word-fall-through queue to decode.
// An entry becomes visible the cycle after imem_ack. Requests need queue credit, and decode stall holds the head.
module if_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [DATA_W-1:0]  imem_rdata,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [DATA_W-1:0]  id_instr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [DATA_W-1:0] q_instr [DEPTH];
  logic              credit;
  logic              push;
  logic              pop;
  logic              unused_bits;

  // The in-flight request reserves a slot, so its response can always be pushed.
  assign credit = ({1'b0, count} + {{CNT_W{1'b0}}, (state != ST_IDLE)}) < (CNT_W + 1)'(DEPTH);

  assign imem_req  = (state == ST_IDLE) & credit & ~stall[0] & ~redirect_valid & ~rst;
  assign imem_addr = fetch_pc;

  assign id_valid  = (count != '0);
  assign id_pc     = q_pc[rd_ptr];
  assign id_instr  = q_instr[rd_ptr];

  assign push = (state == ST_WAIT) & imem_ack & ~redirect_valid;
  assign pop  = id_valid & ~stall[1] & ~redirect_valid;

  assign unused_bits = ^{stall, redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      // An outstanding response must still be swallowed unless it lands this cycle.
      if (state != ST_IDLE) state <= imem_ack ? ST_IDLE : ST_DROP;
    end else begin
      case (state)
        ST_IDLE: begin
          if (imem_req) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(4);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT, ST_DROP: begin
          if (imem_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (push) begin
        q_pc[wr_ptr]    <= req_pc;
        q_instr[wr_ptr] <= imem_rdata;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule
